// File: rtl/training_sequencer_pkg.sv
// Shared types for the training sequencer: Q8.8 fixed point, activation and sequencer state enums.
// Saturating arithmetic helpers used by the gradient datapath.
package training_sequencer_pkg;

  localparam int unsigned SFP_W  = 16;
  localparam int unsigned FRAC_W = 8;
  localparam int unsigned WIDE_W = 2 * SFP_W;
  localparam int unsigned SUM_W  = SFP_W + 1;

  typedef logic signed [SFP_W-1:0] sfp;

  localparam sfp ONE       = 16'sh0100;
  localparam sfp HALF      = 16'sh0080;
  localparam sfp epsilon   = 16'sh0001;
  localparam sfp ONE_M_EPS = 16'sh00FF;
  localparam sfp SFP_MAX   = 16'sh7FFF;
  localparam sfp SFP_MIN   = 16'sh8000;

  typedef enum logic [1:0] {ACT_SIGMOID, ACT_RELU, ACT_TANH, ACT_LINEAR} act_func;

  typedef enum logic [2:0] {IDLE, TRAIN, EVAL, DRAIN, DONE} seq_state_t;

  typedef enum logic [1:0] {TAG_NONE, TAG_TRAIN, TAG_EVAL} phase_tag_t;

  function automatic sfp sfp_sat(input logic signed [SUM_W-1:0] s);
    if (s[SUM_W-1] != s[SUM_W-2]) return s[SUM_W-1] ? SFP_MIN : SFP_MAX;
    return sfp'(s);
  endfunction

  function automatic sfp sfp_add(input sfp a, input sfp b);
    return sfp_sat(SUM_W'(a) + SUM_W'(b));
  endfunction

  function automatic sfp sfp_sub(input sfp a, input sfp b);
    return sfp_sat(SUM_W'(a) - SUM_W'(b));
  endfunction

  // Division by zero saturates towards the sign of the numerator.
  function automatic sfp sfp_div(input sfp a, input sfp b);
    logic signed [WIDE_W-1:0] num;
    logic signed [WIDE_W-1:0] den;
    logic signed [WIDE_W-1:0] q;
    if (b == '0) return (a < 0) ? SFP_MIN : SFP_MAX;
    num = WIDE_W'(a) <<< FRAC_W;
    den = WIDE_W'(b);
    q   = num / den;
    if (q > WIDE_W'(SFP_MAX)) return SFP_MAX;
    if (q < WIDE_W'(SFP_MIN)) return SFP_MIN;
    return sfp'(q);
  endfunction

endpackage

// File: rtl/training_sequencer_bce_gradient.sv
// Combinational binary-cross-entropy gradient for one prediction/label pair.
// TRAINING_SEQUENCER_GRAD_CLAMP_EN clamps the prediction to [epsilon, ONE-epsilon] before dividing.
module bce_gradient
  import training_sequencer_pkg::*;
(
  input  sfp prediction,
  input  sfp expected,
  output sfp gradient
);

  sfp p_use;
  sfp p_eps;
  sfp t_pos;
  sfp t_neg;

  always_comb begin
`ifdef TRAINING_SEQUENCER_GRAD_CLAMP_EN
    if (prediction < epsilon)        p_use = epsilon;
    else if (prediction > ONE_M_EPS) p_use = ONE_M_EPS;
    else                             p_use = prediction;
`else
    p_use = prediction;
`endif
    p_eps    = sfp_add(p_use, epsilon);
    t_pos    = sfp_div(expected, p_eps);
    t_neg    = sfp_div(sfp_sub(ONE, expected), sfp_sub(ONE, p_eps));
    gradient = sfp_sub('0, sfp_sub(t_pos, t_neg));
  end

endmodule

// File: rtl/training_sequencer.sv
// Steps a perceptron through TRAIN/EVAL passes over a small sample table for a number of epochs.
// Build option TRAINING_SEQUENCER_GRAD_CLAMP_EN is handled inside bce_gradient.
module training_sequencer
  import training_sequencer_pkg::*;
#(
  parameter int unsigned INPUT_UNITS  = 2,
  parameter int unsigned NUM_SAMPLES  = 4,
  parameter int unsigned PRED_LATENCY = 1,
  localparam int unsigned ADDR_W = (NUM_SAMPLES > 1) ? $clog2(NUM_SAMPLES) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  sfp                wr_values [INPUT_UNITS],
  input  sfp                wr_expected,
  input  logic              start,
  input  logic [15:0]       epochs,
  input  sfp                prediction,
  output sfp                values [INPUT_UNITS],
  output logic              training,
  output act_func           activation,
  output sfp                learning_rate,
  output sfp                error_gradient,
  output logic              busy,
  output logic              done,
  output logic [15:0]       epoch_idx,
  output logic [6:0]        correct_count
);

  localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(NUM_SAMPLES - 1);
  localparam logic [1:0]        LAST_DRAIN = 2'(PRED_LATENCY - 1);

  seq_state_t        state, state_next;
  logic [ADDR_W-1:0] idx, idx_next;
  logic [1:0]        drain_cnt, drain_next;
  logic [15:0]       epochs_q, epochs_next, epoch_next;

  sfp tbl_values   [NUM_SAMPLES][INPUT_UNITS];
  sfp tbl_expected [NUM_SAMPLES];

  logic       busy_d, done_d, training_d;
  sfp         values_d [INPUT_UNITS];
  sfp         exp_d, exp_drv;
  phase_tag_t tag_d, tag_drv;

  phase_tag_t tag_pipe [PRED_LATENCY];
  sfp         exp_pipe [PRED_LATENCY];
  sfp         grad_raw;
  logic       hit;
  logic [6:0] scratch;
  logic       addr_ok;

  wire last_sample = (idx == LAST_IDX);
  wire last_drain  = (drain_cnt == LAST_DRAIN);

  assign activation    = ACT_SIGMOID;
  assign learning_rate = ONE;

  if ((1 << ADDR_W) == NUM_SAMPLES) begin : g_addr_full
    assign addr_ok = 1'b1;
  end else begin : g_addr_part
    assign addr_ok = (32'(wr_addr) < NUM_SAMPLES);
  end

  // Sample table has no reset so a mid-run reset leaves it intact.
  always_ff @(posedge clk) begin
    if (state == IDLE && wr_en && addr_ok) begin
      tbl_values[wr_addr]   <= wr_values;
      tbl_expected[wr_addr] <= wr_expected;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      drain_cnt <= '0;
      epochs_q  <= '0;
      epoch_idx <= '0;
    end else begin
      state     <= state_next;
      idx       <= idx_next;
      drain_cnt <= drain_next;
      epochs_q  <= epochs_next;
      epoch_idx <= epoch_next;
    end
  end

  always_comb begin
    state_next  = state;
    idx_next    = idx;
    drain_next  = drain_cnt;
    epochs_next = epochs_q;
    epoch_next  = epoch_idx;
    case (state)
      IDLE: if (start) begin
        epochs_next = epochs;
        epoch_next  = '0;
        idx_next    = '0;
        drain_next  = '0;
        state_next  = (epochs == '0) ? EVAL : TRAIN;
      end
      TRAIN: if (last_sample) begin
        idx_next   = '0;
        state_next = EVAL;
      end else begin
        idx_next = idx + 1'b1;
      end
      EVAL: if (last_sample) begin
        idx_next   = '0;
        drain_next = '0;
        state_next = DRAIN;
      end else begin
        idx_next = idx + 1'b1;
      end
      DRAIN: if (last_drain) begin
        drain_next = '0;
        epoch_next = epoch_idx + 16'd1;
        state_next = (17'(epoch_idx) + 17'd1 < 17'(epochs_q)) ? TRAIN : DONE;
      end else begin
        drain_next = drain_cnt + 2'd1;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Decoded from the next state so the registered outputs line up with the state register.
  always_comb begin
    busy_d     = (state_next != IDLE);
    done_d     = (state_next == DONE);
    training_d = (state_next == TRAIN);
    tag_d      = TAG_NONE;
    exp_d      = '0;
    for (int i = 0; i < INPUT_UNITS; i++) values_d[i] = '0;
    if (state_next == TRAIN || state_next == EVAL) begin
      tag_d    = (state_next == TRAIN) ? TAG_TRAIN : TAG_EVAL;
      exp_d    = tbl_expected[idx_next];
      values_d = tbl_values[idx_next];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      training <= 1'b0;
      tag_drv  <= TAG_NONE;
      exp_drv  <= '0;
      for (int i = 0; i < INPUT_UNITS; i++) values[i] <= '0;
    end else begin
      busy     <= busy_d;
      done     <= done_d;
      training <= training_d;
      tag_drv  <= tag_d;
      exp_drv  <= exp_d;
      values   <= values_d;
    end
  end

  // Label and phase follow the driven sample through the perceptron's latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < PRED_LATENCY; i++) begin
        tag_pipe[i] <= TAG_NONE;
        exp_pipe[i] <= '0;
      end
    end else begin
      tag_pipe[0] <= tag_drv;
      exp_pipe[0] <= exp_drv;
      for (int i = 1; i < PRED_LATENCY; i++) begin
        tag_pipe[i] <= tag_pipe[i-1];
        exp_pipe[i] <= exp_pipe[i-1];
      end
    end
  end

  bce_gradient u_grad (
    .prediction (prediction),
    .expected   (exp_pipe[PRED_LATENCY-1]),
    .gradient   (grad_raw)
  );

  assign error_gradient = (tag_pipe[PRED_LATENCY-1] == TAG_TRAIN) ? grad_raw : '0;
  assign hit = (tag_pipe[PRED_LATENCY-1] == TAG_EVAL) &&
               ((prediction < HALF) == (exp_pipe[PRED_LATENCY-1] < HALF));

  // The final eval prediction lands in the last DRAIN cycle, so it is folded in on the copy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scratch       <= '0;
      correct_count <= '0;
    end else if (state == IDLE && start) begin
      scratch <= '0;
    end else if (state == DRAIN && last_drain) begin
      correct_count <= scratch + 7'(hit);
      scratch       <= '0;
    end else if (hit) begin
      scratch <= scratch + 7'd1;
    end
  end

endmodule

// File: tb/tb_training_sequencer.sv
// Directed bench for training_sequencer: AND-table runs, gradient values, mid-run abuse and reset.
module tb_training_sequencer;
  import training_sequencer_pkg::*;

  localparam int unsigned NU = 2;
  localparam int unsigned NS = 4;
  localparam int unsigned PL = 1;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic [1:0]  wr_addr;
  sfp          wr_values [NU];
  sfp          wr_expected;
  logic        start;
  logic [15:0] epochs;
  sfp          prediction;
  sfp          values [NU];
  logic        training;
  act_func     activation;
  sfp          learning_rate;
  sfp          error_gradient;
  logic        busy;
  logic        done;
  logic [15:0] epoch_idx;
  logic [6:0]  correct_count;

  logic pred_mode;
  sfp   pred_const;
  sfp   model_q;

  int n_vec = 0;
  int n_bad = 0;

  training_sequencer #(
    .INPUT_UNITS (NU),
    .NUM_SAMPLES (NS),
    .PRED_LATENCY(PL)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_values     (wr_values),
    .wr_expected   (wr_expected),
    .start         (start),
    .epochs        (epochs),
    .prediction    (prediction),
    .values        (values),
    .training      (training),
    .activation    (activation),
    .learning_rate (learning_rate),
    .error_gradient(error_gradient),
    .busy          (busy),
    .done          (done),
    .epoch_idx     (epoch_idx),
    .correct_count (correct_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One-cycle-latency stand-in for a perceptron that has learned AND.
  always @(posedge clk) model_q <= (values[0] == ONE && values[1] == ONE) ? ONE : '0;
  assign prediction = pred_mode ? model_q : pred_const;

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic write_sample(input int a, input sfp v0, input sfp v1, input sfp e);
    @(negedge clk);
    wr_en        = 1'b1;
    wr_addr      = 2'(a);
    wr_values[0] = v0;
    wr_values[1] = v1;
    wr_expected  = e;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      if (!busy) break;
      @(negedge clk);
    end
    check("idle_timeout", 32'(busy), 0);
  endtask

  // Runs one job; counts busy (non-done) cycles, training cycles and done pulses.
  task automatic run_job(input int n, input int inject_at, output int busy_cyc,
                         output int train_cyc, output int done_cyc, output int busy_after);
    logic seen;
    busy_cyc  = 0;
    train_cyc = 0;
    done_cyc  = 0;
    seen      = 1'b0;
    @(negedge clk);
    epochs = 16'(n);
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (i == inject_at) begin
        start        = 1'b1;
        wr_en        = 1'b1;
        wr_addr      = 2'd3;
        wr_values[0] = ONE;
        wr_values[1] = ONE;
        wr_expected  = '0;
      end else begin
        start = 1'b0;
        wr_en = 1'b0;
      end
      if (busy && !done) busy_cyc++;
      if (training) train_cyc++;
      if (done) begin
        done_cyc++;
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    start = 1'b0;
    wr_en = 1'b0;
    if (!seen) check("run_timeout", 0, 1);
    @(negedge clk);
    if (done) done_cyc++;
    busy_after = 32'(busy);
  endtask

  initial begin
    int bc, tc, dc, ba;
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_expected = '0;
    wr_values[0] = '0; wr_values[1] = '0;
    start = 1'b0; epochs = '0; pred_mode = 1'b0; pred_const = '0;
    repeat (3) @(negedge clk);

    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_training", 32'(training), 0);
    check("rst_values0", 32'(values[0]), 0);
    check("rst_values1", 32'(values[1]), 0);
    check("rst_grad", 32'(error_gradient), 0);
    check("rst_epoch", 32'(epoch_idx), 0);
    check("rst_correct", 32'(correct_count), 0);
    check("act_const", 32'(activation), 32'(ACT_SIGMOID));
    check("lr_const", 32'(learning_rate), 256);
    rst = 1'b0;

    write_sample(0, '0, '0, '0);
    write_sample(1, '0, ONE, '0);
    write_sample(2, ONE, '0, '0);
    write_sample(3, ONE, ONE, ONE);

    pred_mode = 1'b1;
    run_job(1, -1, bc, tc, dc, ba);
    check("e1_busy", bc, 9);
    check("e1_train", tc, 4);
    check("e1_done", dc, 1);
    check("e1_idle", ba, 0);
    check("e1_epoch", 32'(epoch_idx), 1);
    check("e1_correct", 32'(correct_count), 4);

    pred_mode = 1'b0; pred_const = '0;
    run_job(1, -1, bc, tc, dc, ba);
    check("pred0_correct", 32'(correct_count), 3);
    pred_const = ONE;
    run_job(1, -1, bc, tc, dc, ba);
    check("pred1_correct", 32'(correct_count), 1);

    pred_mode = 1'b1;
    run_job(10, -1, bc, tc, dc, ba);
    check("e10_busy", bc, 90);
    check("e10_train", tc, 40);
    check("e10_done", dc, 1);
    check("e10_epoch", 32'(epoch_idx), 10);
    check("e10_correct", 32'(correct_count), 4);

    pred_mode = 1'b0; pred_const = '0;
    run_job(0, -1, bc, tc, dc, ba);
    check("e0_train", tc, 0);
    check("e0_busy", bc, 5);
    check("e0_done", dc, 1);
    check("e0_correct", 32'(correct_count), 3);

    // Gradient with prediction held at HALF.
    pred_const = HALF;
    @(negedge clk); epochs = 16'd1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("grad_first", 32'(error_gradient), 0);
    check("drv_idx0", 32'(values[0]), 0);
    @(negedge clk);
    check("grad_half_lbl0", 32'(error_gradient), 516);
    repeat (2) @(negedge clk);
    check("drv_idx3", 32'(values[0]), 256);
    check("drv_idx3_train", 32'(training), 1);
    @(negedge clk);
    check("grad_half_lbl1", 32'(error_gradient), -508);
    check("eval_train", 32'(training), 0);
    @(negedge clk);
    check("grad_eval_zero", 32'(error_gradient), 0);
    wait_idle();

    // Gradient with prediction at zero.
    pred_const = '0;
    @(negedge clk); epochs = 16'd1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
`ifdef TRAINING_SEQUENCER_GRAD_CLAMP_EN
    check("grad_zero_lbl0", 32'(error_gradient), 258);
`else
    check("grad_zero_lbl0", 32'(error_gradient), 257);
`endif
    repeat (3) @(negedge clk);
    check("grad_zero_lbl1", 32'(error_gradient), -32767);
    wait_idle();

    // start and a table write mid-TRAIN must be ignored.
    pred_mode = 1'b1;
    run_job(1, 1, bc, tc, dc, ba);
    check("inj_busy", bc, 9);
    check("inj_done", dc, 1);
    check("inj_correct", 32'(correct_count), 4);
    run_job(1, -1, bc, tc, dc, ba);
    check("inj_table_kept", 32'(correct_count), 4);

    // Reset in the middle of EVAL.
    @(negedge clk); epochs = 16'd3; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);
    check("pre_rst_busy", 32'(busy), 1);
    check("pre_rst_eval", 32'(training), 0);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_values0", 32'(values[0]), 0);
    check("mid_rst_values1", 32'(values[1]), 0);
    check("mid_rst_grad", 32'(error_gradient), 0);
    check("mid_rst_epoch", 32'(epoch_idx), 0);
    check("mid_rst_correct", 32'(correct_count), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    dc = 0; bc = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) dc++;
      if (busy) bc++;
    end
    check("post_rst_done", dc, 0);
    check("post_rst_busy", bc, 0);
    run_job(1, -1, bc, tc, dc, ba);
    check("post_rst_table", 32'(correct_count), 4);
    check("post_rst_epoch", 32'(epoch_idx), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
